// File: rtl/maze_mem.sv
// Maze wall/visited storage: raster load, registered solver reads and path marks, visited dump.
// Optional MAZE_MEM_WALL_GUARD_EN drops path marks on wall cells and flags we_err.
module maze_mem #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned CNT_W  = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] row,
    input  logic [ADDR_W-1:0] col,
    input  logic              maze_oe,
    input  logic              maze_we,
    output logic              maze_in,
    input  logic              load_valid,
    input  logic              load_data,
    output logic              load_ready,
    output logic              mem_ready,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_data,
    output logic              dump_last,
    output logic [CNT_W-1:0]  path_cnt,
    output logic              we_err
);

    localparam int unsigned IDX_W = 2 * ADDR_W;
    localparam int unsigned CELLS = 1 << IDX_W;

    typedef enum logic [1:0] {StLoad, StServe, StDump} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               maze_in_q, maze_in_d;
    logic [CNT_W-1:0]   path_cnt_q, path_cnt_d;

    logic               wall_mem    [CELLS];
    logic               visited_mem [CELLS];

    logic [IDX_W-1:0]   cell_addr;
    logic               idx_last;
    logic               load_fire;
    logic               serving;
    logic               mark_drop;
    logic               mark_en;

    assign cell_addr = {row, col};
    assign idx_last  = &idx_q;
    assign load_fire = (state_q == StLoad) && load_valid;
    assign serving   = (state_q == StServe);

`ifdef MAZE_MEM_WALL_GUARD_EN
    logic we_err_q, we_err_d;

    assign mark_drop = wall_mem[cell_addr];

    always_comb begin
        we_err_d = we_err_q;
        if (load_fire && idx_last) begin
            we_err_d = 1'b0;
        end else if (serving && maze_we && mark_drop) begin
            we_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_err_q <= 1'b0;
        end else begin
            we_err_q <= we_err_d;
        end
    end

    assign we_err = we_err_q;
`else
    assign mark_drop = 1'b0;
    assign we_err    = 1'b0;
`endif

    assign mark_en = serving && maze_we && !mark_drop;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        maze_in_d  = maze_in_q;
        path_cnt_d = path_cnt_q;
        unique case (state_q)
            StLoad: begin
                // A solver released early must only ever see walls.
                maze_in_d = 1'b1;
                if (load_fire) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_last) begin
                        state_d    = StServe;
                        path_cnt_d = '0;
                    end
                end
            end
            StServe: begin
                if (maze_oe) begin
                    maze_in_d = wall_mem[cell_addr];
                end
                if (mark_en && !visited_mem[cell_addr]) begin
                    path_cnt_d = path_cnt_q + 1'b1;
                end
                if (dump_start) begin
                    state_d = StDump;
                    idx_d   = '0;
                end
            end
            StDump: begin
                if (dump_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_last) begin
                        state_d = StServe;
                    end
                end
            end
            default: begin
                state_d = StLoad;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            idx_q      <= '0;
            maze_in_q  <= 1'b1;
            path_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            maze_in_q  <= maze_in_d;
            path_cnt_q <= path_cnt_d;
        end
    end

    // Map arrays carry no reset; a completed load defines every cell.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            wall_mem[idx_q]    <= load_data;
            visited_mem[idx_q] <= 1'b0;
        end else if (mark_en) begin
            visited_mem[cell_addr] <= 1'b1;
        end
    end

    assign maze_in    = maze_in_q;
    assign path_cnt   = path_cnt_q;
    assign load_ready = (state_q == StLoad);
    assign mem_ready  = serving;
    assign dump_valid = (state_q == StDump);
    assign dump_data  = dump_valid & visited_mem[idx_q];
    assign dump_last  = dump_valid & idx_last;

endmodule

// File: tb/tb_maze_mem.sv
// Randomized self-checking bench for maze_mem against a cell-array reference model.
module tb_maze_mem;

    localparam int AW = 6;
    localparam int CW = 13;
    localparam int N  = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] row = '0;
    logic [AW-1:0] col = '0;
    logic          maze_oe = 1'b0;
    logic          maze_we = 1'b0;
    logic          maze_in;
    logic          load_valid = 1'b0;
    logic          load_data = 1'b0;
    logic          load_ready;
    logic          mem_ready;
    logic          dump_start = 1'b0;
    logic          dump_valid;
    logic          dump_ready = 1'b0;
    logic          dump_data;
    logic          dump_last;
    logic [CW-1:0] path_cnt;
    logic          we_err;

    maze_mem #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row        (row),
        .col        (col),
        .maze_oe    (maze_oe),
        .maze_we    (maze_we),
        .maze_in    (maze_in),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .mem_ready  (mem_ready),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .path_cnt   (path_cnt),
        .we_err     (we_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit wall_m   [N];
    bit vis_m    [N];
    bit next_map [N];
    int cnt_m   = 0;
    bit exp_in  = 1'b1;
    bit err_m   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_junk();
        maze_oe = 1'($urandom % 2);
        maze_we = 1'($urandom % 2);
        row     = AW'($urandom_range(0, 63));
        col     = AW'($urandom_range(0, 63));
    endtask

    task automatic load_map(input int beats);
        int gap;
        for (int i = 0; i < beats; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                load_valid = 1'b0;
                rand_junk();
                dump_start = 1'($urandom % 2);
                step();
                check("load_maze_in", maze_in, 1);
            end
            maze_oe    = 1'b0;
            maze_we    = 1'b0;
            dump_start = 1'b0;
            load_valid = 1'b1;
            load_data  = next_map[i];
            if (i == N - 1) check("pre_last_mem_ready", mem_ready, 0);
            step();
        end
        load_valid = 1'b0;
        if (beats == N) begin
            for (int i = 0; i < N; i++) begin
                wall_m[i] = next_map[i];
                vis_m[i]  = 1'b0;
            end
            cnt_m  = 0;
            err_m  = 1'b0;
            exp_in = 1'b1;
            check("load_done_mem_ready", mem_ready, 1);
            check("load_done_load_ready", load_ready, 0);
            check("load_done_path_cnt", path_cnt, 0);
            check("load_done_we_err", we_err, 0);
        end
    endtask

    task automatic serve_cycle(input bit oe, input bit we, input int r, input int c);
        int  i;
        bit  drop;
        i       = r * 64 + c;
        maze_oe = oe;
        maze_we = we;
        row     = AW'(r);
        col     = AW'(c);
        step();
        if (oe) exp_in = wall_m[i];
        if (we) begin
            drop = 1'b0;
`ifdef MAZE_MEM_WALL_GUARD_EN
            drop = wall_m[i];
`endif
            if (drop) err_m = 1'b1;
            else if (!vis_m[i]) begin
                vis_m[i] = 1'b1;
                cnt_m++;
            end
        end
        maze_oe = 1'b0;
        maze_we = 1'b0;
        check("serve_maze_in", maze_in, exp_in);
        check("serve_path_cnt", path_cnt, cnt_m);
        check("serve_we_err", we_err, err_m);
    endtask

    task automatic dump_check();
        int beat;
        int cyc;
        beat = 0;
        cyc  = 0;
        maze_oe    = 1'b0;
        maze_we    = 1'b0;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        while (beat < N && cyc < 20000) begin
            dump_ready = 1'($urandom % 2);
            rand_junk();
            if (dump_valid !== 1'b1) begin
                check("dump_valid", dump_valid, 1);
                break;
            end
            check("dump_data", dump_data, vis_m[beat]);
            check("dump_last", dump_last, (beat == N - 1));
            if (dump_ready) beat++;
            step();
            cyc++;
        end
        dump_ready = 1'b0;
        maze_oe    = 1'b0;
        maze_we    = 1'b0;
        check("dump_beats", beat, N);
        check("dump_end_valid", dump_valid, 0);
        check("dump_end_mem_ready", mem_ready, 1);
        check("dump_hold_maze_in", maze_in, exp_in);
        check("dump_hold_path_cnt", path_cnt, cnt_m);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_maze_in", maze_in, 1);
        check("rst_load_ready", load_ready, 1);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dump_data", dump_data, 0);
        check("rst_dump_last", dump_last, 0);
        check("rst_path_cnt", path_cnt, 0);
        check("rst_we_err", we_err, 0);
        rst_n = 1'b1;
        step();

        // Border walls with an opening at (0,5)
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                next_map[r * 64 + c] = (r == 0 || r == 63 || c == 0 || c == 63);
        next_map[5] = 1'b0;
        load_map(N);

        serve_cycle(1, 0, 0, 0);
        check("read_0_0", maze_in, 1);
        serve_cycle(1, 0, 0, 5);
        check("read_0_5", maze_in, 0);
        serve_cycle(0, 0, 0, 0);
        check("read_hold", maze_in, 0);

        repeat (3) serve_cycle(0, 1, 10, 10);
        serve_cycle(0, 1, 10, 11);
        check("repeat_marks_cnt", path_cnt, 2);

        serve_cycle(1, 1, 20, 3);
        check("oe_we_read", maze_in, 0);
        check("oe_we_cnt", path_cnt, 3);

        dump_check();

        // Random solver traffic then a second dump
        for (int k = 0; k < 400; k++)
            serve_cycle(1'($urandom % 2), ($urandom % 10) < 3,
                        $urandom_range(0, 63), $urandom_range(0, 63));
        dump_check();

        // Partial load interrupted by reset, then a full random reload
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) next_map[i] = 1'($urandom % 2);
        load_map(1000);
        rst_n = 1'b0;
        #1;
        check("midrst_load_ready", load_ready, 1);
        check("midrst_mem_ready", mem_ready, 0);
        check("midrst_maze_in", maze_in, 1);
        check("midrst_path_cnt", path_cnt, 0);
        step();
        rst_n = 1'b1;
        cnt_m = 0;
        err_m = 1'b0;
        for (int i = 0; i < N; i++) next_map[i] = 1'($urandom % 2);
        next_map[0] = 1'b1;
        load_map(N);

        for (int k = 0; k < 60; k++)
            serve_cycle(1, 0, $urandom_range(0, 63), $urandom_range(0, 63));
        serve_cycle(1, 1, 0, 0);
        check("wall_read_0_0", maze_in, 1);
        dump_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
